// File: rtl/adventure_game_v2_pkg.sv
// Shared types for the adventure game: room encoding, room count and the
// one-hot room decode used by the LED outputs.
package adventure_pkg;

  typedef enum logic [2:0] {
    ROOM_CAVE   = 3'd0,
    ROOM_TUNNEL = 3'd1,
    ROOM_RIVER  = 3'd2,
    ROOM_STASH  = 3'd3,
    ROOM_DEN    = 3'd4,
    ROOM_GRAVE  = 3'd5,
    ROOM_VAULT  = 3'd6
  } room_t;

  localparam int unsigned N_ROOMS = 7;

  // Bit k set when the room code equals k.
  function automatic logic [N_ROOMS-1:0] room_onehot(input room_t r);
    logic [N_ROOMS-1:0] oh;
    oh    = '0;
    oh[r] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/adventure_game_v2_if.sv
// Button/status bundle between the board and the game block. The board side
// (master) drives the direction buttons; the game (slave) drives room LEDs
// and the status display.
interface adventure_game_v2_if #(
  parameter int unsigned MOVE_W = 8
);
  import adventure_pkg::*;

  logic                 n;
  logic                 s;
  logic                 e;
  logic                 w;
  room_t                room;
  logic [N_ROOMS-1:0]   room_oh;
  logic                 sw;
  logic                 v;
  logic                 win;
  logic                 d;
  logic [2:0]           lives_left;
  logic                 game_over;
  logic [MOVE_W-1:0]    moves;
  logic                 timeout;

  modport master (
    output n, s, e, w,
    input  room, room_oh, sw, v, win, d, lives_left, game_over, moves, timeout
  );

  modport slave (
    input  n, s, e, w,
    output room, room_oh, sw, v, win, d, lives_left, game_over, moves, timeout
  );

endinterface

// File: rtl/adventure_game_v2_sword_keeper.sv
// Holds the sword flag and the sticky dragon-vanquished flag. Set wins over
// clear; the game never asks for both in one cycle.
module sword_keeper (
  input  logic clk,
  input  logic reset,
  input  logic set,
  input  logic clear,
  input  logic resolve,
  output logic sw,
  output logic v
);

  logic sw_q, sw_d;
  logic v_q, v_d;

  // Next-value logic for sword and vanquished flags.
  always_comb begin
    sw_d = sw_q;
    v_d  = v_q | resolve;
    if (set) begin
      sw_d = 1'b1;
    end else if (clear) begin
      sw_d = 1'b0;
    end
  end

  // Flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_q <= 1'b0;
      v_q  <= 1'b0;
    end else begin
      sw_q <= sw_d;
      v_q  <= v_d;
    end
  end

  assign sw = sw_q;
  assign v  = v_q;

endmodule

// File: rtl/adventure_game_v2.sv
// Adventure game top: room FSM, lives counter with respawn and move counter.
// Optional move limit compiled in with ADVENTURE_MOVE_LIMIT_EN; without it
// timeout stays 0 and the move count is informational only.
module adventure_game_v2 #(
  parameter int unsigned LIVES     = 3,
  parameter int unsigned MOVE_W    = 8,
  parameter int unsigned MAX_MOVES = 50
) (
  input logic               clk,
  input logic               reset,
  adventure_game_v2_if.slave bus
);
  import adventure_pkg::*;

`ifdef ADVENTURE_MOVE_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  localparam logic [MOVE_W-1:0] MOVE_CAP = MOVE_W'(MAX_MOVES);

  room_t             room_q, room_d;
  logic [2:0]        lives_q, lives_d;
  logic              over_q, over_d;
  logic [MOVE_W-1:0] moves_q, moves_d;
  logic              timeout_q, timeout_d;

  logic       sw, v;
  logic       sw_set, sw_clr, dragon_win;
  logic       move_step;
  logic [3:0] dirs;
  logic       dir_valid;
  logic       terminal;

  assign dirs      = {bus.n, bus.s, bus.e, bus.w};
  assign dir_valid = (dirs != 4'b0000) && ((dirs & (dirs - 4'd1)) == 4'b0000);
  assign terminal  = (room_q == ROOM_VAULT) || ((room_q == ROOM_GRAVE) && over_q);

  // Room transitions, lives/respawn, move counting and move-limit override.
  always_comb begin
    room_d     = room_q;
    lives_d    = lives_q;
    over_d     = over_q;
    moves_d    = moves_q;
    timeout_d  = timeout_q;
    sw_set     = 1'b0;
    sw_clr     = 1'b0;
    dragon_win = 1'b0;
    move_step  = 1'b0;

    case (room_q)
      ROOM_CAVE: begin
        if (dir_valid && bus.e) begin
          room_d    = ROOM_TUNNEL;
          move_step = 1'b1;
        end
      end
      ROOM_TUNNEL: begin
        if (dir_valid && bus.s) begin
          room_d    = ROOM_RIVER;
          move_step = 1'b1;
        end else if (dir_valid && bus.w) begin
          room_d = ROOM_CAVE;
        end
      end
      ROOM_RIVER: begin
        if (dir_valid && bus.n) begin
          room_d    = ROOM_TUNNEL;
          move_step = 1'b1;
        end else if (dir_valid && bus.w) begin
          room_d    = ROOM_STASH;
          move_step = 1'b1;
          sw_set    = 1'b1;
        end else if (dir_valid && bus.e) begin
          room_d    = ROOM_DEN;
          move_step = 1'b1;
        end
      end
      ROOM_STASH: begin
        if (dir_valid && bus.e) begin
          room_d    = ROOM_RIVER;
          move_step = 1'b1;
        end
      end
      ROOM_DEN: begin
        if (sw) begin
          room_d     = ROOM_VAULT;
          dragon_win = 1'b1;
        end else begin
          room_d = ROOM_GRAVE;
        end
      end
      ROOM_GRAVE: begin
        if (!over_q) begin
          if (lives_q > 3'd1) begin
            lives_d = lives_q - 3'd1;
            sw_clr  = 1'b1;
            room_d  = ROOM_CAVE;
          end else begin
            lives_d = '0;
            over_d  = 1'b1;
          end
        end
      end
      ROOM_VAULT: begin
        over_d = 1'b1;
      end
      default: begin
        room_d = ROOM_CAVE;
      end
    endcase

    if (move_step && (moves_q != '1)) begin
      moves_d = moves_q + 1'b1;
    end

    // Limit hit overrides everything decided above for this cycle.
    if (LIMIT_EN && (moves_q == MOVE_CAP) && !terminal) begin
      room_d     = ROOM_GRAVE;
      lives_d    = '0;
      over_d     = 1'b1;
      timeout_d  = 1'b1;
      moves_d    = moves_q;
      sw_set     = 1'b0;
      sw_clr     = 1'b0;
      dragon_win = 1'b0;
    end
  end

  // Game state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      room_q    <= ROOM_CAVE;
      lives_q   <= 3'(LIVES);
      over_q    <= 1'b0;
      moves_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      room_q    <= room_d;
      lives_q   <= lives_d;
      over_q    <= over_d;
      moves_q   <= moves_d;
      timeout_q <= timeout_d;
    end
  end

  sword_keeper u_sword_keeper (
    .clk     (clk),
    .reset   (reset),
    .set     (sw_set),
    .clear   (sw_clr),
    .resolve (dragon_win),
    .sw      (sw),
    .v       (v)
  );

  assign bus.room       = room_q;
  assign bus.room_oh    = room_onehot(room_q);
  assign bus.sw         = sw;
  assign bus.v          = v;
  assign bus.win        = (room_q == ROOM_VAULT);
  assign bus.d          = (room_q == ROOM_GRAVE);
  assign bus.lives_left = lives_q;
  assign bus.game_over  = over_q;
  assign bus.moves      = moves_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_adventure_game_v2.sv
// Self-checking bench for adventure_game_v2: directed vector table, hand
// sequences on a single-life small-counter instance, and random play checked
// against a room-map reference model.
module tb_adventure_game_v2;

`ifdef ADVENTURE_MOVE_LIMIT_EN
  localparam bit TB_LIMIT = 1'b1;
`else
  localparam bit TB_LIMIT = 1'b0;
`endif

  localparam logic [3:0] DN = 4'b1000;
  localparam logic [3:0] DS = 4'b0100;
  localparam logic [3:0] DE = 4'b0010;
  localparam logic [3:0] DW = 4'b0001;
  localparam logic [3:0] D0 = 4'b0000;

  localparam int L0 = 3, MW0 = 8, MM0 = 50;
  localparam int L1 = 1, MW1 = 3, MM1 = 4;

  typedef struct packed {
    logic [2:0] room;
    logic       sw;
    logic       v;
    logic [2:0] lives;
    logic       over;
    logic [7:0] moves;
    logic       tmo;
  } mdl_t;

  typedef struct packed {
    logic       rst;
    logic [3:0] dirs;
    mdl_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst0, rst1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   dest_tbl [7][4];

  adventure_game_v2_if #(.MOVE_W(MW0)) bus0 ();
  adventure_game_v2_if #(.MOVE_W(MW1)) bus1 ();

  adventure_game_v2 #(.LIVES(L0), .MOVE_W(MW0), .MAX_MOVES(MM0)) dut0 (
    .clk(clk), .reset(rst0), .bus(bus0)
  );
  adventure_game_v2 #(.LIVES(L1), .MOVE_W(MW1), .MAX_MOVES(MM1)) dut1 (
    .clk(clk), .reset(rst1), .bus(bus1)
  );

  always #5 clk = ~clk;

  function automatic mdl_t mk(int room, bit sw, bit v, int lives, bit over, int moves, bit tmo);
    mdl_t r;
    r.room  = 3'(room);
    r.sw    = sw;
    r.v     = v;
    r.lives = 3'(lives);
    r.over  = over;
    r.moves = 8'(moves);
    r.tmo   = tmo;
    return r;
  endfunction

  // Reference: game rules applied to a room map, one clock per call.
  function automatic mdl_t mstep(mdl_t m, bit rst, logic [3:0] dirs, int lives0, int maxm, int mw);
    mdl_t r;
    int   idx, dest, room, cap;
    bit   term;
    r    = m;
    room = int'(m.room);
    cap  = (1 << mw) - 1;
    if (rst) return mk(0, 0, 0, lives0, 0, 0, 0);
    term = (room == 6) || (room == 5 && m.over);
    if (TB_LIMIT && int'(m.moves) == maxm && !term) begin
      r.room = 3'd5; r.lives = 3'd0; r.over = 1'b1; r.tmo = 1'b1;
      return r;
    end
    if (room == 4) begin
      if (m.sw) begin r.room = 3'd6; r.v = 1'b1; end
      else r.room = 3'd5;
    end else if (room == 5) begin
      if (!m.over) begin
        if (m.lives > 1) begin r.lives = m.lives - 3'd1; r.sw = 1'b0; r.room = 3'd0; end
        else begin r.lives = 3'd0; r.over = 1'b1; end
      end
    end else if (room == 6) begin
      r.over = 1'b1;
    end else if ($countones(dirs) == 1) begin
      idx  = dirs[3] ? 0 : dirs[2] ? 1 : dirs[1] ? 2 : 3;
      dest = dest_tbl[room][idx];
      if (dest >= 0) begin
        r.room = 3'(dest);
        if (dest != 0 && int'(m.moves) < cap) r.moves = m.moves + 8'd1;
        if (dest == 3) r.sw = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_main(string tag, mdl_t e);
    chk({tag, ".room"},    32'(bus0.room),       32'(e.room));
    chk({tag, ".room_oh"}, 32'(bus0.room_oh),    32'(1) << e.room);
    chk({tag, ".sw"},      32'(bus0.sw),         32'(e.sw));
    chk({tag, ".v"},       32'(bus0.v),          32'(e.v));
    chk({tag, ".win"},     32'(bus0.win),        32'(e.room == 3'd6));
    chk({tag, ".d"},       32'(bus0.d),          32'(e.room == 3'd5));
    chk({tag, ".lives"},   32'(bus0.lives_left), 32'(e.lives));
    chk({tag, ".over"},    32'(bus0.game_over),  32'(e.over));
    chk({tag, ".moves"},   32'(bus0.moves),      32'(e.moves));
    chk({tag, ".timeout"}, 32'(bus0.timeout),    32'(e.tmo));
  endtask

  task automatic chk_b1(string tag, mdl_t e);
    chk({tag, ".room"},    32'(bus1.room),       32'(e.room));
    chk({tag, ".room_oh"}, 32'(bus1.room_oh),    32'(1) << e.room);
    chk({tag, ".sw"},      32'(bus1.sw),         32'(e.sw));
    chk({tag, ".v"},       32'(bus1.v),          32'(e.v));
    chk({tag, ".win"},     32'(bus1.win),        32'(e.room == 3'd6));
    chk({tag, ".d"},       32'(bus1.d),          32'(e.room == 3'd5));
    chk({tag, ".lives"},   32'(bus1.lives_left), 32'(e.lives));
    chk({tag, ".over"},    32'(bus1.game_over),  32'(e.over));
    chk({tag, ".moves"},   32'(bus1.moves),      32'(e.moves));
    chk({tag, ".timeout"}, 32'(bus1.timeout),    32'(e.tmo));
  endtask

  task automatic drive0(bit rst, logic [3:0] dirs);
    rst0 = rst;
    {bus0.n, bus0.s, bus0.e, bus0.w} = dirs;
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(bit rst, logic [3:0] dirs);
    rst1 = rst;
    {bus1.n, bus1.s, bus1.e, bus1.w} = dirs;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t vec(bit rst, logic [3:0] dirs, mdl_t e);
    vec_t t;
    t.rst = rst; t.dirs = dirs; t.exp = e;
    return t;
  endfunction

  initial begin
    vec_t        vecs [$];
    mdl_t        m;
    logic [3:0]  dirs;
    bit          rst;
    int          r;

    foreach (dest_tbl[i, j]) dest_tbl[i][j] = -1;
    dest_tbl[0][2] = 1;
    dest_tbl[1][1] = 2; dest_tbl[1][3] = 0;
    dest_tbl[2][0] = 1; dest_tbl[2][3] = 3; dest_tbl[2][2] = 4;
    dest_tbl[3][2] = 2;

    rst0 = 1'b1; rst1 = 1'b1;
    {bus0.n, bus0.s, bus0.e, bus0.w} = D0;
    {bus1.n, bus1.s, bus1.e, bus1.w} = D0;

    // Death without sword, respawn, then win; terminal hold.
    vecs.push_back(vec(1, D0, mk(0, 0, 0, 3, 0, 0, 0)));
    vecs.push_back(vec(0, DE, mk(1, 0, 0, 3, 0, 1, 0)));
    vecs.push_back(vec(0, DS, mk(2, 0, 0, 3, 0, 2, 0)));
    vecs.push_back(vec(0, DE, mk(4, 0, 0, 3, 0, 3, 0)));
    vecs.push_back(vec(0, DW, mk(5, 0, 0, 3, 0, 3, 0)));
    vecs.push_back(vec(0, DE, mk(0, 0, 0, 2, 0, 3, 0)));
    vecs.push_back(vec(0, DE, mk(1, 0, 0, 2, 0, 4, 0)));
    vecs.push_back(vec(0, DS, mk(2, 0, 0, 2, 0, 5, 0)));
    vecs.push_back(vec(0, DW, mk(3, 1, 0, 2, 0, 6, 0)));
    vecs.push_back(vec(0, DE, mk(2, 1, 0, 2, 0, 7, 0)));
    vecs.push_back(vec(0, DE, mk(4, 1, 0, 2, 0, 8, 0)));
    vecs.push_back(vec(0, D0, mk(6, 1, 1, 2, 0, 8, 0)));
    vecs.push_back(vec(0, DN, mk(6, 1, 1, 2, 1, 8, 0)));
    vecs.push_back(vec(0, DW, mk(6, 1, 1, 2, 1, 8, 0)));
    vecs.push_back(vec(0, DS, mk(6, 1, 1, 2, 1, 8, 0)));
    // Ambiguous / illegal requests, then reset from River with sword.
    vecs.push_back(vec(1, DE, mk(0, 0, 0, 3, 0, 0, 0)));
    vecs.push_back(vec(0, DN | DE, mk(0, 0, 0, 3, 0, 0, 0)));
    vecs.push_back(vec(0, DW, mk(0, 0, 0, 3, 0, 0, 0)));
    vecs.push_back(vec(0, 4'b1111, mk(0, 0, 0, 3, 0, 0, 0)));
    vecs.push_back(vec(0, DE, mk(1, 0, 0, 3, 0, 1, 0)));
    vecs.push_back(vec(0, DS | DW, mk(1, 0, 0, 3, 0, 1, 0)));
    vecs.push_back(vec(0, DS, mk(2, 0, 0, 3, 0, 2, 0)));
    vecs.push_back(vec(0, DW, mk(3, 1, 0, 3, 0, 3, 0)));
    vecs.push_back(vec(0, DE, mk(2, 1, 0, 3, 0, 4, 0)));
    vecs.push_back(vec(1, DE, mk(0, 0, 0, 3, 0, 0, 0)));

    foreach (vecs[i]) begin
      drive0(vecs[i].rst, vecs[i].dirs);
      chk_main($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Single life: final death is terminal.
    drive1(1, D0); chk_b1("l1.rst", mk(0, 0, 0, 1, 0, 0, 0));
    drive1(0, DE); drive1(0, DS);
    drive1(0, DE); chk_b1("l1.den", mk(4, 0, 0, 1, 0, 3, 0));
    drive1(0, D0); chk_b1("l1.grave", mk(5, 0, 0, 1, 0, 3, 0));
    drive1(0, DE); chk_b1("l1.dead", mk(5, 0, 0, 0, 1, 3, 0));
    for (int i = 0; i < 5; i++) begin
      drive1(0, 4'($urandom_range(0, 15)));
      chk_b1($sformatf("l1.hold%0d", i), mk(5, 0, 0, 0, 1, 3, 0));
    end

    // Move limit / saturation on the 3-bit counter.
    drive1(1, D0);
    for (int i = 0; i < 7; i++) drive1(0, (i % 2 == 0) ? DE : DW);
    chk_b1("lim.pre", mk(1, 0, 0, 1, 0, 4, 0));
    drive1(0, DW);
    if (TB_LIMIT) begin
      chk_b1("lim.hit", mk(5, 0, 0, 0, 1, 4, 1));
      drive1(0, DE);
      chk_b1("lim.hold", mk(5, 0, 0, 0, 1, 4, 1));
    end else begin
      chk_b1("lim.none", mk(0, 0, 0, 1, 0, 4, 0));
      for (int i = 0; i < 8; i++) drive1(0, (i % 2 == 0) ? DE : DW);
      chk_b1("sat", mk(0, 0, 0, 1, 0, 7, 0));
    end

    // Random play against the reference model.
    m = mk(0, 0, 0, L0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      rst = (i == 0) || ($urandom_range(0, 149) == 0);
      r   = $urandom_range(0, 9);
      if (r < 7)       dirs = 4'(1 << $urandom_range(0, 3));
      else if (r == 7) dirs = D0;
      else             dirs = 4'($urandom_range(0, 15));
      drive0(rst, dirs);
      m = mstep(m, rst, dirs, L0, MM0, MW0);
      chk_main($sformatf("rnd%0d", i), m);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/adventure_game_v2.md
# adventure_game_v2

Parametrised successor to the single-life adventure game. It tracks the player's room, sword, dragon and win/death state, and adds a lives counter with respawn, rejection of ambiguous multi-direction input, and an optional move limit. It is the top-level game block driven directly by the board's direction buttons. Its outputs drive the room LEDs and the status display.

## Interface
- `LIVES`, default 3: starting lives, legal range 1..7.
- `MOVE_W`, default 8: width of the move counter.
- `MAX_MOVES`, default 50: move limit, used only when the move limit is compiled in. Must be less than 2**MOVE_W.

- `clk` input, 1: single system clock, rising edge.
- `reset` input, 1: synchronous, active-high. Has priority over all other inputs.
- `n`, `s`, `e`, `w` input, 1 each: direction requests, level-sampled every cycle.
- `room` output, 3: current room code (`room_t`).
- `room_oh` output, 7: one-hot room, bit k set when `room == k`. Bits 0–6 correspond to s0–s6.
- `sw` output, 1: player holds the sword.
- `v` output, 1: dragon vanquished (sticky).
- `win` output, 1: player is in Victory Vault.
- `d` output, 1: player is in Grievous Graveyard.
- `lives_left` output, 3: remaining lives.
- `game_over` output, 1: game finished, either by win or by final death.
- `moves` output, MOVE_W: count of legal room-changing moves.
- `timeout` output, 1: move limit hit.

## Operation
- Room codes:
  - 0 Cave (start)
  - 1 Twisty Tunnel
  - 2 Rapid River
  - 3 Sword Stash
  - 4 Dragon's Den
  - 5 Graveyard
  - 6 Victory Vault
- Valid request: exactly one of n/s/e/w is high. Zero or two-plus directions high means no move.
- Legal moves:
  - Cave: E → Tunnel.
  - Tunnel: S → River, W → Cave.
  - River: N → Tunnel, W → Stash, E → Den.
  - Stash: E → River.
  - Any other valid direction leaves the room unchanged and is not counted.
- Entering Stash sets `sw`. `sw` stays set until respawn or reset.
- Den resolves automatically and ignores all inputs:
  - `sw` = 1: go to Vault and set `v`.
  - `sw` = 0: go to Graveyard.
- Graveyard, ignoring inputs:
  - `lives_left` > 1: decrement `lives_left`, clear `sw`, go to Cave (respawn).
  - `lives_left` == 1: set it to 0, set `game_over`, stay in Graveyard.
- Vault: set `game_over`, stay in Vault.
- Terminal states (Vault, or Graveyard with `game_over`) hold until reset and ignore all direction inputs.
- `win` = (room == Vault). `d` = (room == Graveyard). Both are decoded from the registered room.
- `moves` increments on each legal room change into Tunnel, River, Stash or Den. It is not incremented on automatic transitions, saturates at all-ones, and is not cleared on respawn.

## Timing
- Reset values: `room` = 0, `room_oh` = 7'b0000001, `sw` = 0, `v` = 0, `win` = 0, `d` = 0, `lives_left` = LIVES, `game_over` = 0, `moves` = 0, `timeout` = 0.
- All outputs are registered or decoded from registers. There are no combinational paths from inputs to outputs.
- Move latency: a request sampled at edge k takes effect in `room` after edge k.
- `sw` is set on the same edge that `room` becomes Stash.
- Den dwells exactly 1 cycle. Graveyard before respawn dwells exactly 1 cycle, with `d` = 1 for that cycle.
- Holding a button moves once per cycle. Debouncing and edge detection happen outside this block.
- Reset asserted mid-game restores reset values on the next edge, whatever the state.

## Configuration
- Macro: `ADVENTURE_MOVE_LIMIT_EN`.
- Defined:
  - When `moves` == MAX_MOVES and the room is not terminal, the next edge sets `timeout` = 1 and `game_over` = 1, moves the player to Graveyard, and forces `lives_left` to 0.
  - A timeout takes priority over a move request or Den resolution in the same cycle.
- Undefined: `timeout` is tied to 0. `moves` still counts but has no effect on play.

## Structure
- Package `adventure_pkg` holds:
  - `typedef enum logic [2:0] room_t` with the codes above.
  - `N_ROOMS` = 7.
  - The one-hot decode function.
- Sub-module `sword_keeper`:
  - Inputs: `clk`, `reset`, set (entering Stash), clear (respawn), dragon resolve.
  - Outputs: `sw` and `v`.
  - Set has priority over clear; the two never occur together.
- The top holds the room FSM, lives counter and move counter.

## Test plan
- Reset, then E, S, E with no sword → Den for 1 cycle, then Graveyard with `d` = 1 and `lives_left` 3 → 2, then Cave with `sw` = 0.
- From Cave: E, S, W (Stash, `sw` = 1), E, E → Den → Vault; `win` = 1, `v` = 1, `game_over` = 1, `moves` = 5. Further inputs leave all outputs unchanged.
- LIVES = 1, die once → `lives_left` = 0, `game_over` = 1, room stays 5 indefinitely.
- n = e = 1 together in Cave → no move and `moves` unchanged. W in Cave → no move.
- Reset asserted while in River with `sw` = 1 → all outputs at reset values after the next edge.
- With `ADVENTURE_MOVE_LIMIT_EN` and MAX_MOVES = 4: bounce E/W in Cave/Tunnel four times → next edge gives `timeout` = 1, room = 5, `lives_left` = 0.
